// File: rtl/request_dispatch_pkg.sv
// Shared types, sizes and mask helpers for the request dispatcher.
// Macro REQ_DISPATCH_RR_EN selects round-robin arbitration in request_dispatcher.
package request_dispatch_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    typedef logic [N_REQ-1:0] req_vec_t;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } disp_state_t;

    function automatic req_vec_t onehot(input logic [IDX_W-1:0] idx);
        req_vec_t one;
        one = req_vec_t'(1);
        return one << idx;
    endfunction

    // Bits strictly above idx; idx = N_REQ-1 yields zero, which forces the next pick unmasked.
    function automatic req_vec_t mask_above(input logic [IDX_W-1:0] idx);
        req_vec_t ones;
        ones = '1;
        return ~(ones >> (IDX_W'(N_REQ - 1) - idx));
    endfunction

endpackage

// File: rtl/request_dispatcher_priority_encoder.sv
// Combinational 32-bit priority encoder: lowest set bit wins.
// Used unmodified in both fixed-priority and round-robin builds of request_dispatcher.
module priority_encoder
    import request_dispatch_pkg::*;
(
    input  logic [N_REQ-1:0] data_i,
    output logic [IDX_W-1:0] data_o,
    output logic             valid_o
);

    always_comb begin
        data_o  = '0;
        valid_o = |data_i;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                data_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/request_dispatcher.sv
// Sticky 32-line request collector that offers one pending index at a time on valid/ready.
// Define REQ_DISPATCH_RR_EN for round-robin selection; default is fixed lowest-index priority.
module request_dispatcher
    import request_dispatch_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             clear_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_idx_o,
    input  logic             grant_ready_i,
    output logic [N_REQ-1:0] pending_o,
    output logic             busy_o
);

    // Handshake: an offer is taken on any rising edge where grant_valid_o && grant_ready_i;
    // grant_idx_o never changes while grant_valid_o is high and not yet taken.

    disp_state_t      state_q, state_d;
    req_vec_t         pending_q, pending_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    req_vec_t         clr_mask;
    req_vec_t         enc_in;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             accept;

    assign accept   = (state_q == ST_OFFER) && grant_ready_i;
    assign clr_mask = accept ? onehot(grant_idx_q) : '0;

`ifdef REQ_DISPATCH_RR_EN
    req_vec_t rr_mask_q, rr_mask_d;
    req_vec_t masked;

    assign masked = pending_q & rr_mask_q;
    assign enc_in = (|masked) ? masked : pending_q;

    always_comb begin
        rr_mask_d = rr_mask_q;
        if (clear_i) begin
            rr_mask_d = '1;
        end else if (accept) begin
            rr_mask_d = mask_above(grant_idx_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_mask_q <= '1;
        end else begin
            rr_mask_q <= rr_mask_d;
        end
    end
`else
    assign enc_in = pending_q;
`endif

    priority_encoder u_prio_enc (
        .data_i  (enc_in),
        .data_o  (enc_idx),
        .valid_o (enc_valid)
    );

    // A request in the same cycle as its own clear wins, so nothing is lost.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | req_i;
        if (clear_i) begin
            pending_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        grant_idx_d = enc_idx;
                        state_d     = ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (grant_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_valid_o = (state_q == ST_OFFER);
    assign grant_idx_o   = grant_idx_q;
    assign pending_o     = pending_q;
    assign busy_o        = (state_q == ST_OFFER);

endmodule
